// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: word/byte widths and loader states.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int BYTE_W  = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 8-to-32 packer: the first byte of a word ends up in bits 31:24.
module byte_packer
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               byte_valid,
   input  logic [BYTE_W-1:0]  data,
   output logic               word_valid,
   output logic [INSTR_W-1:0] word
);

   logic [INSTR_W-BYTE_W-1:0] shift;
   logic [1:0]                idx;

   // The 4th byte completes the word combinationally so the caller can register it at once.
   assign word_valid = byte_valid && (idx == 2'd3);
   assign word       = {shift, data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= '0;
         idx   <= 2'd0;
      end else if (clear) begin
         shift <= '0;
         idx   <= 2'd0;
      end else if (byte_valid) begin
         shift <= {shift[INSTR_W-2*BYTE_W-1:0], data};
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a framed byte stream, writes 32-bit words into imem, verifies an XOR checksum.
module imem_loader
   import mips_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [31:0]        imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [ADDR_W:0]    words_loaded
);

   localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

   loader_state_t       state;
   logic [BYTE_W-1:0]   len_hi;
   logic [15:0]         len;
   logic [15:0]         word_idx;
   logic [BYTE_W-1:0]   csum;
   logic                accept;
   logic                start_ok;
   logic                pack_valid;
   logic                word_valid;
   logic [INSTR_W-1:0]  word;
   logic [15:0]         len_next;

   assign rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
   assign accept   = rx_valid && rx_ready;
   assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign pack_valid = accept && (state == DATA);
   assign len_next = {len_hi, rx_data};

   assign cpu_hold = (state != DONE);
   assign done     = (state == DONE);
   assign error    = (state == ERR);

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok),
      .byte_valid (pack_valid),
      .data       (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len_hi       <= '0;
         len          <= '0;
         word_idx     <= '0;
         csum         <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start_ok) begin
            state        <= LEN_HI;
            csum         <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
         end else if (accept) begin
            case (state)
               LEN_HI: begin
                  len_hi <= rx_data;
                  state  <= LEN_LO;
               end
               LEN_LO: begin
                  len <= len_next;
                  if ({1'b0, len_next} > DEPTH) state <= ERR;
                  else if (len_next == 16'd0)   state <= CSUM;
                  else                          state <= DATA;
               end
               DATA: begin
                  csum <= csum ^ rx_data;
                  // Word k is written on the cycle after its 4th byte; address is byte-granular.
                  if (word_valid) begin
                     imem_we      <= 1'b1;
                     imem_addr    <= BASE_ADDR + (32'(word_idx) << 2);
                     imem_wdata   <= word;
                     words_loaded <= words_loaded + (ADDR_W+1)'(1);
                     word_idx     <= word_idx + 16'd1;
                     if (word_idx == len - 16'd1) state <= CSUM;
                  end
               end
               CSUM: begin
                  state <= (rx_data == csum) ? DONE : ERR;
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader, checked against a frame-level reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;

   logic        rx_ready0, imem_we0, cpu_hold0, done0, error0;
   logic [31:0] imem_addr0, imem_wdata0;
   logic [8:0]  words_loaded0;
   logic        rx_ready1, imem_we1, cpu_hold1, done1, error1;
   logic [31:0] imem_addr1, imem_wdata1;
   logic [8:0]  words_loaded1;

   int n_chk = 0;
   int n_fail = 0;
   int last_cycles = 0;

   logic [7:0]  fr[$];
   logic [31:0] exp_w[$];
   bit          exp_done, exp_err;
   logic [63:0] q0[$];
   logic [63:0] q1[$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
      .cpu_hold(cpu_hold0), .done(done0), .error(error0), .words_loaded(words_loaded0));

   imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0100)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
      .cpu_hold(cpu_hold1), .done(done1), .error(error1), .words_loaded(words_loaded1));

   always @(negedge clk) begin
      if (imem_we0) q0.push_back({imem_addr0, imem_wdata0});
      if (imem_we1) q1.push_back({imem_addr1, imem_wdata1});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: words written = complete words received; status from length and checksum.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_w.delete();
      exp_done = 0;
      exp_err  = 0;
      n = int'({fr[0], fr[1]});
      if (n > 256) begin
         exp_err = 1;
         return;
      end
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
         exp_w.push_back({fr[2+4*k], fr[3+4*k], fr[4+4*k], fr[5+4*k]});
         for (int b = 0; b < 4; b++) x = x ^ fr[2+4*k+b];
      end
      if (fr[2+4*n] == x) exp_done = 1;
      else                exp_err  = 1;
   endtask

   task automatic make_frame(input int n, input bit bad);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      logic [15:0] len = 16'(n);
      fr.delete();
      fr.push_back(len[15:8]);
      fr.push_back(len[7:0]);
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         fr.push_back(b);
      end
      fr.push_back(bad ? ~x : x);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("start_hold", {31'd0, cpu_hold0}, 32'd1);
      check("start_done", {30'd0, done0, error0}, 32'd0);
      check("start_wl", {23'd0, words_loaded0}, 32'd0);
   endtask

   task automatic send(input int nbytes, input int pct, input int start_at);
      int i = 0;
      int cyc = 0;
      while (i < nbytes && cyc < 5000) begin
         @(negedge clk);
         start    = (i == start_at) && (cyc == 0 || start == 1'b0) && (start_at >= 0);
         rx_data  = fr[i];
         rx_valid = ($urandom_range(99) < pct);
         if (start) start_at = -1;
         if (rx_valid && rx_ready0) i++;
         cyc++;
      end
      if (i < nbytes) check("send_timeout", i, nbytes);
      last_cycles = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic run(input string tag, input int pct, input int start_at);
      int nb;
      model();
      nb = (int'({fr[0], fr[1]}) > 256) ? 2 : fr.size();
      q0.delete();
      q1.delete();
      pulse_start();
      send(nb, pct, start_at);
      repeat (3) @(negedge clk);
      check({tag, "_nwr0"}, q0.size(), exp_w.size());
      check({tag, "_nwr1"}, q1.size(), exp_w.size());
      for (int k = 0; k < exp_w.size(); k++) begin
         if (k < q0.size()) begin
            check({tag, "_addr0"}, q0[k][63:32], 32'(4*k));
            check({tag, "_data0"}, q0[k][31:0], exp_w[k]);
         end
         if (k < q1.size()) begin
            check({tag, "_addr1"}, q1[k][63:32], 32'h100 + 32'(4*k));
            check({tag, "_data1"}, q1[k][31:0], exp_w[k]);
         end
      end
      check({tag, "_done"}, {31'd0, done0}, {31'd0, exp_done});
      check({tag, "_error"}, {31'd0, error0}, {31'd0, exp_err});
      check({tag, "_hold"}, {31'd0, cpu_hold0}, {31'd0, !exp_done});
      check({tag, "_ready"}, {31'd0, rx_ready0}, 32'd0);
      check({tag, "_wl"}, {23'd0, words_loaded0}, 32'(exp_w.size()));
      check({tag, "_st1"}, {30'd0, done1, error1}, {30'd0, exp_done, exp_err});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, {31'd0, rx_ready0}, 32'd0);
      check({tag, "_we"}, {31'd0, imem_we0}, 32'd0);
      check({tag, "_addr"}, imem_addr0, 32'd0);
      check({tag, "_wdata"}, imem_wdata0, 32'd0);
      check({tag, "_hold"}, {31'd0, cpu_hold0}, 32'd1);
      check({tag, "_dnerr"}, {30'd0, done0, error0}, 32'd0);
      check({tag, "_wl"}, {23'd0, words_loaded0}, 32'd0);
      check({tag, "_addr1"}, imem_addr1, 32'd0);
   endtask

   initial begin
      #12;
      check_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Nominal frame, source streaming every cycle
      fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
      run("nominal", 100, -1);
      check("nominal_cycles", last_cycles, 11);
      check("nominal_w0", exp_w[0], 32'h2008_0005);

      fr[10] = 8'hFF;
      run("badcsum", 100, -1);

      fr = '{8'h01, 8'h01};
      run("oversize", 100, -1);

      fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
      run("flow", 50, 5);

      fr = '{8'h00, 8'h00, 8'h00};
      run("zero", 100, -1);
      fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
      run("reload", 100, -1);

      // Reset asserted after the 2nd data byte of a frame
      q0.delete();
      pulse_start();
      send(4, 100, -1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_nowr", q0.size(), 0);
      run("postrst", 100, -1);

      make_frame(256, 0);
      run("maxlen", 100, -1);

      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(4) == 0) begin
            fr.delete();
            fr.push_back(8'h01);
            fr.push_back(8'($urandom_range(255, 1)));
         end else begin
            make_frame($urandom_range(6), ($urandom_range(3) == 0));
         end
         run("rand", $urandom_range(100, 30), $urandom_range(int'(fr.size()) + 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
